// File: rtl/y86_mem_pkg.sv
// Shared types for the Y86 data-memory bridge and lane helpers.
package y86_mem_pkg;

    localparam int WORD_W = 32;
    localparam logic [3:0] BE_ALL  = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE
    } state_e;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [31:0]       addr;
        logic [3:0]        be;
        logic [WORD_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/y86_lane_shift.sv
// Little-endian byte-lane steering for a word access that may straddle two
// aligned words: byte enables and write data per beat, plus read merge.
module y86_lane_shift
    import y86_mem_pkg::*;
(
    input  logic [1:0]        off_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [WORD_W-1:0] rdata0_i,
    input  logic [WORD_W-1:0] rdata1_i,
    output logic [3:0]        be0_o,
    output logic [3:0]        be1_o,
    output logic [WORD_W-1:0] wdata0_o,
    output logic [WORD_W-1:0] wdata1_o,
    output logic [WORD_W-1:0] rdata_o
);

    logic [5:0]          sh_bits;
    logic [7:0]          be_wide;
    logic [2*WORD_W-1:0] w_wide;

    // Shifting into a double-width vector gives both beats at once: the
    // low half is beat 0, the bytes pushed past the word are beat 1.
    always_comb begin
        sh_bits = {off_i, 3'b000};
        be_wide = {BE_NONE, BE_ALL} << off_i;
        w_wide  = {{WORD_W{1'b0}}, wdata_i} << sh_bits;
        rdata_o = WORD_W'({rdata1_i, rdata0_i} >> sh_bits);
    end

    assign be0_o    = be_wide[3:0];
    assign be1_o    = be_wide[7:4];
    assign wdata0_o = w_wide[WORD_W-1:0];
    assign wdata1_o = w_wide[2*WORD_W-1:WORD_W];

endmodule

// File: rtl/y86_dmem_bridge.sv
// Bridges the Y86 memory stage to a req/ack SRAM bus, splitting unaligned
// word accesses into two aligned beats and stalling the pipeline meanwhile.
module y86_dmem_bridge #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_wdata_i,
    output logic [WORD_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [WORD_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [WORD_W-1:0] bus_rdata_i
);
    import y86_mem_pkg::*;

    state_e            state_q;
    bus_req_t          bus_q;
    logic [1:0]        off_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata0_q;
    logic [WORD_W-1:0] rdata_q;

    logic              cpu_req;
    logic [31:0]       base_d;
    logic [1:0]        sh_off;
    logic [WORD_W-1:0] sh_wdata;
    logic [WORD_W-1:0] sh_rdata0;
    logic [WORD_W-1:0] rdata_d;
    logic [3:0]        be0;
    logic [3:0]        be1;
    logic [WORD_W-1:0] wdata0;
    logic [WORD_W-1:0] wdata1;

    assign cpu_req = cpu_read_i | cpu_write_i;
    assign base_d  = {cpu_addr_i[31:2], 2'b00};

    // In IDLE the beat-0 lanes come straight from the CPU so they can be
    // registered on the accepting edge; afterwards the latched copy is used.
    always_comb begin
        sh_off    = (state_q == IDLE) ? cpu_addr_i[1:0] : off_q;
        sh_wdata  = (state_q == IDLE) ? cpu_wdata_i : wdata_q;
        sh_rdata0 = (state_q == BEAT1) ? rdata0_q : bus_rdata_i;
    end

    y86_lane_shift u_lane (
        .off_i    (sh_off),
        .wdata_i  (sh_wdata),
        .rdata0_i (sh_rdata0),
        .rdata1_i (bus_rdata_i),
        .be0_o    (be0),
        .be1_o    (be1),
        .wdata0_o (wdata0),
        .wdata1_o (wdata1),
        .rdata_o  (rdata_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            bus_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        state_q     <= BEAT0;
                        bus_q.req   <= 1'b1;
                        bus_q.we    <= cpu_write_i;
                        bus_q.addr  <= base_d;
                        bus_q.be    <= be0;
                        bus_q.wdata <= wdata0;
                    end
                end
                BEAT0: begin
                    if (bus_ack_i) begin
                        if (off_q != 2'b00) begin
                            state_q     <= BEAT1;
                            bus_q.addr  <= bus_q.addr + 32'd4;
                            bus_q.be    <= be1;
                            bus_q.wdata <= wdata1;
                        end else begin
                            state_q <= DONE;
                            bus_q   <= '0;
                            if (!bus_q.we) rdata_q <= rdata_d;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ack_i) begin
                        state_q <= DONE;
                        bus_q   <= '0;
                        if (!bus_q.we) rdata_q <= rdata_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request operands and the first beat's read data carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && cpu_req) begin
            off_q   <= cpu_addr_i[1:0];
            wdata_q <= cpu_wdata_i;
        end
        if (state_q == BEAT0 && bus_ack_i) rdata0_q <= bus_rdata_i;
    end

    assign cpu_stall_o = rst & (((state_q == IDLE) & cpu_req) |
                                (state_q == BEAT0) | (state_q == BEAT1));
    assign cpu_rdata_o = rdata_q;
    assign bus_req_o   = bus_q.req;
    assign bus_we_o    = bus_q.we;
    assign bus_addr_o  = bus_q.addr;
    assign bus_be_o    = bus_q.be;
    assign bus_wdata_o = bus_q.wdata;

endmodule

// File: tb/tb_y86_dmem_bridge.sv
// Bench for y86_dmem_bridge: byte-array SRAM slave with per-beat wait states
// and scoreboards for expected bus beats and read results.
module tb_y86_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read_i, cpu_write_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic        cpu_stall_o;
    logic        bus_req_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;

    y86_dmem_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_read_i  (cpu_read_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    bit [7:0]    mem[bit [31:0]];
    int          n_total = 0;
    int          n_bad   = 0;
    int          w0 = 0, w1 = 0, cnt = 0, beat_idx = 0;
    bit          ack_given = 1'b0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = d[i*8 +: 8];
    endtask

    // Expected beats built byte by byte: each CPU byte k lands in the word
    // holding address a+k, in lane (a+k)%4.
    task automatic push_beats(input bit we, input logic [31:0] a, input logic [31:0] wd);
        beat_t       b0, b1;
        logic [31:0] base, ba;
        base = {a[31:2], 2'b00};
        b0 = '{we, base, 4'h0, 32'h0};
        b1 = '{we, base + 32'd4, 4'h0, 32'h0};
        for (int k = 0; k < 4; k++) begin
            ba = a + 32'(k);
            if ({ba[31:2], 2'b00} == base) begin
                b0.be[ba[1:0]] = 1'b1;
                b0.wdata[ba[1:0]*8 +: 8] = wd[k*8 +: 8];
            end else begin
                b1.be[ba[1:0]] = 1'b1;
                b1.wdata[ba[1:0]*8 +: 8] = wd[k*8 +: 8];
            end
        end
        beat_q.push_back(b0);
        if (b1.be != 4'h0) beat_q.push_back(b1);
    endtask

    task automatic check_beat();
        beat_t e;
        if (beat_q.size() == 0) begin
            chk("beat_unexpected", 32'd1, 32'd0);
        end else begin
            e = beat_q.pop_front();
            chk("beat_we", {31'd0, bus_we_o}, {31'd0, e.we});
            chk("beat_addr", bus_addr_o, e.addr);
            chk("beat_be", {28'd0, bus_be_o}, {28'd0, e.be});
            if (e.we) chk("beat_wdata", bus_wdata_o, e.wdata);
        end
    endtask

    // SRAM slave: w0/w1 wait cycles before acking beat 0 / beat 1.
    always @(negedge clk) begin
        int w;
        bus_ack_i = 1'b0;
        if (ack_given) begin
            cnt = 0;
            beat_idx++;
            ack_given = 1'b0;
        end
        if (!bus_req_o) begin
            cnt = 0;
            beat_idx = 0;
        end else begin
            w = (beat_idx == 0) ? w0 : w1;
            if (cnt >= w) begin
                check_beat();
                bus_ack_i   = 1'b1;
                ack_given   = 1'b1;
                bus_rdata_i = rd_word(bus_addr_o);
                if (bus_we_o)
                    for (int i = 0; i < 4; i++)
                        if (bus_be_o[i]) mem[bus_addr_o + 32'(i)] = bus_wdata_o[i*8 +: 8];
            end else begin
                cnt++;
            end
        end
    end

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input int wv0, input int wv1);
        int          stalls, exp_stalls, guard;
        bit          split;
        logic [31:0] exp_rd;
        @(negedge clk);
        w0 = wv0;
        w1 = wv1;
        split = (a[1:0] != 2'b00);
        push_beats(we, a, wd);
        if (!we) begin
            for (int k = 0; k < 4; k++) exp_rd[k*8 +: 8] = rd_byte(a + 32'(k));
            last_rd = exp_rd;
        end
        rd_q.push_back(last_rd);
        cpu_read_i  = !we;
        cpu_write_i = we;
        cpu_addr_i  = a;
        cpu_wdata_i = we ? wd : $urandom;
        #1;
        chk("stall_on_req", {31'd0, cpu_stall_o}, 32'd1);
        stalls = 1;
        @(posedge clk);
        #1;
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
        guard = 0;
        while (guard < 60) begin
            @(negedge clk);
            if (!cpu_stall_o) break;
            stalls++;
            guard++;
        end
        if (guard >= 60) chk("timeout", 32'd1, 32'd0);
        exp_stalls = 2 + wv0 + (split ? 1 + wv1 : 0);
        chk("stall_cycles", stalls, exp_stalls);
        chk("rdata", cpu_rdata_o, rd_q.pop_front());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b0;
        cpu_read_i = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_wdata_i = 32'h0;
        bus_ack_i = 1'b0;
        bus_rdata_i = 32'h0;

        repeat (3) @(negedge clk);
        cpu_read_i = 1'b1;
        #1;
        chk("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
        chk("rst_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_we", {31'd0, bus_we_o}, 32'd0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_be", {28'd0, bus_be_o}, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_rdata", cpu_rdata_o, 32'h0);
        cpu_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        set_word(32'h100, 32'hDEADBEEF);
        access(1'b0, 32'h100, 32'h0, 0, 0);
        chk("aligned_rd_const", cpu_rdata_o, 32'hDEADBEEF);

        access(1'b1, 32'h204, 32'h11223344, 2, 2);
        chk("mem_204", rd_word(32'h204), 32'h11223344);
        chk("wr_keeps_rdata", cpu_rdata_o, 32'hDEADBEEF);

        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        access(1'b0, 32'h101, 32'h0, 0, 0);
        chk("split_rd_const", cpu_rdata_o, 32'h55443322);

        access(1'b1, 32'h103, 32'hAABBCCDD, 0, 1);
        chk("mem_100", rd_word(32'h100), 32'hDD332211);
        chk("mem_104", rd_word(32'h104), 32'h88AABBCC);

        set_word(32'hFFFFFFFC, 32'hA1B2C3D4);
        set_word(32'h0, 32'h55667788);
        access(1'b0, 32'hFFFFFFFE, 32'h0, 1, 0);
        chk("wrap_rd_const", cpu_rdata_o, 32'h7788A1B2);

        for (int a = 32'h300; a < 32'h344; a++) mem[32'(a)] = 8'($urandom);
        for (int i = 0; i < 16; i++)
            access(1'($urandom_range(0, 1)), 32'h300 + $urandom_range(0, 60),
                   $urandom, $urandom_range(0, 2), $urandom_range(0, 2));

        // Abandon a split read while beat 1 is waiting on the slave.
        @(negedge clk);
        w0 = 0;
        w1 = 1000;
        push_beats(1'b0, 32'h101, 32'h0);
        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h101;
        @(posedge clk);
        #1;
        cpu_read_i = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 20 && !found; g++) begin
            @(negedge clk);
            if (bus_req_o && bus_addr_o == 32'h104) found = 1'b1;
        end
        #1;
        chk("mid_beat1_seen", {31'd0, found}, 32'd1);
        chk("mid_ack_low", {31'd0, bus_ack_i}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cpu_read_i = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, bus_req_o}, 32'd0);
        chk("mid_rst_be", {28'd0, bus_be_o}, 32'h0);
        chk("mid_rst_stall", {31'd0, cpu_stall_o}, 32'd0);
        chk("mid_rst_rdata", cpu_rdata_o, 32'h0);
        cpu_read_i = 1'b0;
        beat_q.delete();
        last_rd = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 32'h100, 32'h0, 0, 0);
        chk("post_rst_rd", cpu_rdata_o, 32'hDD332211);

        repeat (2) @(negedge clk);
        chk("beat_q_empty", beat_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/y86_dmem_bridge.md
# y86_dmem_bridge

Data-memory bridge downstream of the Y86 pipeline's memory stage. It turns the CPU's single-cycle byte-addressed word access (read or write strobe, address, data) into one or two word-aligned transfers on an external req/ack SRAM bus. It splits unaligned accesses into two beats and merges their byte lanes, little-endian. While a transfer is outstanding it drives a stall back to the pipeline.

## Interface
- `WORD_W`, default 32: CPU and bus data width; must be 32.
- `ADDR_W`, default 32: address width.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst  in  1`: synchronous, active-low reset.
- `cpu_read_i  in  1`: CPU memory read strobe (from the memory stage).
- `cpu_write_i  in  1`: CPU memory write strobe.
- `cpu_addr_i  in  ADDR_W`: byte address; any alignment.
- `cpu_wdata_i  in  WORD_W`: write data.
- `cpu_rdata_o  out  WORD_W`: read result; valid in DONE.
- `cpu_stall_o  out  1`: holds the memory stage and everything upstream.
- `bus_req_o  out  1`: transfer request.
- `bus_we_o  out  1`: 1 = write.
- `bus_addr_o  out  ADDR_W`: word-aligned address; bits [1:0] are always 0.
- `bus_be_o  out  4`: byte enables; bit i selects bits [8i+7:8i].
- `bus_wdata_o  out  WORD_W`: lane-aligned write data.
- `bus_ack_i  in  1`: slave completion; sampled only while `bus_req_o`=1.
- `bus_rdata_i  in  WORD_W`: read data; valid with ack.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - If `cpu_read_i | cpu_write_i`, latch addr, wdata and direction (write wins if both are high), then go to BEAT0.
  - Let off = addr[1:0] and split = (off != 0).
- BEAT0:
  - bus_addr = {addr[31:2],2'b00}.
  - be0 = (4'b1111 << off)[3:0].
  - wdata0 = wdata << 8*off.
  - On ack: capture rdata0; go to BEAT1 if split, else DONE.
- BEAT1:
  - bus_addr = {addr[31:2],2'b00} + 4, modulo 2^32 (0xFFFFFFFD wraps to 0x00000000).
  - be1 = ~be0.
  - wdata1 = wdata >> 8*(4-off).
  - On ack: capture rdata1; go to DONE.
- Read merge:
  - Aligned: rdata0.
  - Split: (rdata0 >> 8*off) | (rdata1 << 8*(4-off)), truncated to 32 bits.
  - Registered into `cpu_rdata_o` when entering DONE.
  - `cpu_rdata_o` holds until the next completed read; writes leave it unchanged.
- DONE: lasts one cycle with stall low, then returns to IDLE. No request is accepted in DONE.
- Stall:
  - `cpu_stall_o` = (IDLE & (read|write)) | BEAT0 | BEAT1.
  - It is combinational from the strobes in IDLE and is 0 in DONE.
- Bus outputs are registered.
  - `bus_req_o`=1 exactly in BEAT0/BEAT1.
  - Addr, be, we and wdata stay stable until ack is sampled.
  - Deasserted in IDLE/DONE; be=0 and wdata=0 there.

## Timing
- Reset (rst=0 at an edge) forces, at that edge:
  - state IDLE.
  - `bus_req_o`=0, `bus_we_o`=0, `bus_addr_o`=0, `bus_be_o`=0, `bus_wdata_o`=0.
  - `cpu_rdata_o`=0.
- `cpu_stall_o` is forced to 0 while rst=0.
- Reset mid-transfer abandons the transfer without waiting for ack; the slave must tolerate a dropped request.
- Aligned access, zero-wait slave (ack in the first req cycle):
  - Request seen in cycle 0 (stall=1).
  - BEAT0 in cycle 1 (stall=1).
  - DONE in cycle 2 (stall=0, rdata valid).
  - Total: 2 stall cycles.
- Split access, zero-wait: 3 stall cycles; DONE in cycle 3.
- Each wait state adds one cycle in the current beat.
- An ack held across the BEAT0→BEAT1 edge completes BEAT1 only if it is still high in the BEAT1 cycle.
- A new request is accepted in the IDLE cycle directly after DONE, so back-to-back accesses cost one extra cycle each.

## Structure
- Shared package `y86_mem_pkg`:
  - state enum.
  - WORD_W and byte-enable constants (BE_ALL=4'hF, BE_NONE=4'h0).
  - bus request struct {req, we, addr, be, wdata}.
- Sub-module `y86_lane_shift`:
  - Combinational.
  - Computes be0/be1, wdata0/wdata1 and the read merge from off.
  - Reused by the planned instruction-fetch aligner.
- Top level holds the FSM and the registers.

## Test plan
- Aligned read, addr 0x100, slave returns 0xDEADBEEF with 0 waits:
  - One beat: bus_addr 0x100, be 4'hF.
  - DONE in cycle 2 with `cpu_rdata_o`=0xDEADBEEF; stall high for exactly 2 cycles.
- Aligned write, addr 0x204, data 0x11223344, slave with 2 wait states:
  - req held 3 cycles; be 4'hF; wdata 0x11223344; we=1.
  - Stall 4 cycles.
- Split read, addr 0x101, mem[0x100]=0x44332211 and mem[0x104]=0x88776655:
  - Beats at 0x100 (be 4'hE) then 0x104 (be 4'h1).
  - Result 0x55443322.
- Split write, addr 0x103, data 0xAABBCCDD:
  - Beat0: 0x100, be 4'h8, wdata 0xDD000000.
  - Beat1: 0x104, be 4'h7, wdata 0x00AABBCC.
- Wrap-around read at 0xFFFFFFFE: beat1 address is 0x00000000 with be 4'h3.
- Reset mid-transfer:
  - Pull rst low during BEAT1 with ack low.
  - Next edge: req=0, state IDLE, stall=0, `cpu_rdata_o`=0.
  - After release, an aligned read completes normally.
